// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline encodings for the hazard controller: opcodes, forwarding selects, NOP, FSM states.
// Definitions only; no timing or flow-control behaviour lives here.
package mips_pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FROZEN  = 2'd2
    } hazState_t;

    typedef struct packed {
        logic       hasDest;
        logic [4:0] dest;
        logic       useRs;
        logic       useRt;
    } decInfo_t;

    function automatic logic isLoad(input logic [31:0] instr);
        return instr[31:26] == OP_LW;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// Register-usage decode of one instruction (upper bits only; shamt/funct never matter).
// Purely combinational, zero latency, no flow control.
module hazard_decode
    import mips_pipe_pkg::*;
(
    input  logic [31:11] instr,
    output decInfo_t     dec
);

    always_comb begin
        dec = '0;
        unique case (instr[31:26])
            OP_RTYPE: begin
                dec.dest  = instr[15:11];
                dec.useRs = 1'b1;
                dec.useRt = 1'b1;
            end
            OP_LW: begin
                dec.dest  = instr[20:16];
                dec.useRs = 1'b1;
            end
            OP_SW, OP_BEQ: begin
                dec.useRs = 1'b1;
                dec.useRt = 1'b1;
            end
            default: ;
        endcase
        // Writes to $0 are discarded by the regfile, so they never create a dependency.
        dec.hasDest = (dec.dest != 5'd0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: stall/bubble/flush/freeze are same-cycle combinational,
// forwarding selects are registered at the D->E edge; mem_wait freezes every state element.
module hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr_d,
    input  logic             valid_d,
    input  logic             branch_taken_e,
    input  logic             mem_wait,
    output logic             stall_f,
    output logic             stall_d,
    output logic             bubble_e,
    output logic             flush_fd,
    output logic             freeze,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [31:0] instrD, shE, shM, shW;
    decInfo_t    dDec, eDec, mDec, wDec;
    hazState_t   state;
    logic [4:0]  rsD, rtD;
    logic [1:0]  fwdA, fwdB;
    logic        loadUse, stallCond;

    assign instrD = valid_d ? instr_d : NOP_WORD;
    assign rsD    = instrD[25:21];
    assign rtD    = instrD[20:16];

    hazard_decode uDecD (.instr(instrD[31:11]), .dec(dDec));
    hazard_decode uDecE (.instr(shE[31:11]),    .dec(eDec));
    hazard_decode uDecM (.instr(shM[31:11]),    .dec(mDec));
    hazard_decode uDecW (.instr(shW[31:11]),    .dec(wDec));

    // A load in E has no result yet, so it is handled by the stall rather than a select.
    always_comb begin
        fwdA = FWD_REG;
        fwdB = FWD_REG;
        if (dDec.useRs) begin
            if (eDec.hasDest && !isLoad(shE) && eDec.dest == rsD) fwdA = FWD_MEM;
            else if (mDec.hasDest && mDec.dest == rsD)            fwdA = FWD_WB;
        end
        if (dDec.useRt) begin
            if (eDec.hasDest && !isLoad(shE) && eDec.dest == rtD) fwdB = FWD_MEM;
            else if (mDec.hasDest && mDec.dest == rtD)            fwdB = FWD_WB;
        end
    end

    assign loadUse = isLoad(shE) && eDec.hasDest &&
                     ((dDec.useRs && rsD == eDec.dest) || (dDec.useRt && rtD == eDec.dest));

    assign stallCond = loadUse && !branch_taken_e && !mem_wait;
    assign freeze    = mem_wait;
    assign flush_fd  = branch_taken_e && !mem_wait;
    assign stall_f   = stallCond;
    assign stall_d   = stallCond;
    assign bubble_e  = (loadUse || branch_taken_e) && !mem_wait;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shE     <= NOP_WORD;
            shM     <= NOP_WORD;
            shW     <= NOP_WORD;
            fwd_a_e <= FWD_REG;
            fwd_b_e <= FWD_REG;
        end else if (!mem_wait) begin
            shW     <= shM;
            shM     <= shE;
            shE     <= bubble_e ? NOP_WORD : instrD;
            fwd_a_e <= bubble_e ? FWD_REG : fwdA;
            fwd_b_e <= bubble_e ? FWD_REG : fwdB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mem_wait) begin
                state <= FROZEN;
            end else begin
                unique case (state)
                    RUN, FROZEN: state <= stallCond ? LDSTALL : RUN;
                    LDSTALL:     state <= RUN;
                    default:     state <= RUN;
                endcase
            end
            if (stallCond && state != LDSTALL && stall_cnt != CNT_MAX)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_fd && flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    // The lw has moved on to M after one stall cycle, so a second stall in a row means a bad shadow.
    assert property (@(posedge clk) disable iff (!rst_n) (state == LDSTALL) |-> !stallCond);
    assert property (@(posedge clk) disable iff (!rst_n)
                     !$isunknown({shE, shM, shW, dDec, eDec, mDec, wDec, state}));

endmodule
